// File: rtl/div_sequencer.sv
// Sequencer between EX and the 64-bit multi-cycle divider: decodes RV64M div/rem ops,
// handles the divide-by-zero and overflow cases locally, and drains the divider on flush.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [TAG_W-1:0] ex_tag,
  output logic             ex_stall,
  output logic             res_valid,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             div_valid,
  output logic             div_signed,
  output logic             divw,
  output logic [XLEN-1:0]  dividend,
  output logic [XLEN-1:0]  divisor,
  output logic             div_flush,
  input  logic             div_ready,
  input  logic             out_valid,
  input  logic [XLEN-1:0]  quot,
  input  logic [XLEN-1:0]  rema
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  resData_q;
  logic [TAG_W-1:0] resTag_q;

  logic             isWord, isSigned, divZero, overflow, special, accept, fastPath;
  logic             cacheHit;
  logic [XLEN-1:0]  cacheQuot, cacheRem;
  logic [XLEN-1:0]  fastQuot, fastRem, fastResult, slowResult;
  logic             completeOk;

  // W results are the low 32 bits sign-extended, unsigned W forms included.
  function automatic logic [XLEN-1:0] shapeResult(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign isWord   = ex_op[2];
  assign isSigned = ~ex_op[0];
  assign divZero  = isWord ? (ex_rs2[31:0] == 32'd0) : (ex_rs2 == '0);
  assign overflow = isSigned &&
                    (isWord ? ((ex_rs1[31:0] == 32'h8000_0000) && (ex_rs2[31:0] == 32'hFFFF_FFFF))
                            : ((ex_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (ex_rs2 == '1)));
  assign special  = divZero || overflow;
  assign accept   = (state_q == IDLE) && ex_valid && !flush && div_ready;
  assign fastPath = special || cacheHit;

  assign fastQuot   = special ? (divZero ? '1 : ex_rs1) : cacheQuot;
  assign fastRem    = special ? (divZero ? ex_rs1 : '0) : cacheRem;
  assign fastResult = shapeResult(ex_op[1] ? fastRem : fastQuot, ex_op[2]);
  assign slowResult = shapeResult(op_q[1] ? rema : quot, op_q[2]);
  assign completeOk = (state_q == BUSY) && out_valid && !flush;

`ifdef DIV_RESULT_CACHE_EN
  logic            cValid_q, cSigned_q, cWord_q;
  logic [XLEN-1:0] cRs1_q, cRs2_q, cQuot_q, cRem_q;

  // Only divider completions that are actually delivered refresh the cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      cValid_q  <= 1'b0;
      cSigned_q <= 1'b0;
      cWord_q   <= 1'b0;
      cRs1_q    <= '0;
      cRs2_q    <= '0;
      cQuot_q   <= '0;
      cRem_q    <= '0;
    end else if (completeOk) begin
      cValid_q  <= 1'b1;
      cSigned_q <= ~op_q[0];
      cWord_q   <= op_q[2];
      cRs1_q    <= rs1_q;
      cRs2_q    <= rs2_q;
      cQuot_q   <= quot;
      cRem_q    <= rema;
    end
  end

  assign cacheHit  = cValid_q && (cRs1_q == ex_rs1) && (cRs2_q == ex_rs2) &&
                     (cSigned_q == isSigned) && (cWord_q == isWord);
  assign cacheQuot = cQuot_q;
  assign cacheRem  = cRem_q;
`else
  assign cacheHit  = 1'b0;
  assign cacheQuot = '0;
  assign cacheRem  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A flush racing the divider result wins: the result is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fastPath ? RESP : BUSY;
      BUSY: begin
        if (flush)          state_d = out_valid ? IDLE : DRAIN;
        else if (out_valid) state_d = RESP;
      end
      DRAIN:   if (out_valid) state_d = IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_valid = (state_q == RESP) && !flush;
    div_valid = (state_q == BUSY);
    ex_stall  = ex_valid && !flush && (state_q != RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      tag_q     <= '0;
      resData_q <= '0;
      resTag_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= ex_op;
        rs1_q <= ex_rs1;
        rs2_q <= ex_rs2;
        tag_q <= ex_tag;
      end
      if (accept && fastPath) begin
        resData_q <= fastResult;
        resTag_q  <= ex_tag;
      end else if (completeOk) begin
        resData_q <= slowResult;
        resTag_q  <= tag_q;
      end
    end
  end

  assign res_data   = resData_q;
  assign res_tag    = resTag_q;
  assign dividend   = rs1_q;
  assign divisor    = rs2_q;
  assign div_signed = ~op_q[0];
  assign divw       = op_q[2];
  assign div_flush  = flush;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer with a behavioural 129-cycle divider model.
module tb_div_sequencer;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  localparam logic [2:0] OP_DIV   = 3'b000;
  localparam logic [2:0] OP_DIVU  = 3'b001;
  localparam logic [2:0] OP_REM   = 3'b010;
  localparam logic [2:0] OP_REMU  = 3'b011;
  localparam logic [2:0] OP_DIVW  = 3'b100;
  localparam logic [2:0] OP_DIVUW = 3'b101;
  localparam logic [2:0] OP_REMW  = 3'b110;

  logic             clk = 1'b0;
  logic             reset, flush, ex_valid;
  logic [2:0]       ex_op;
  logic [XLEN-1:0]  ex_rs1, ex_rs2;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_stall, res_valid;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic             div_valid, div_signed, divw, div_flush, div_ready, out_valid;
  logic [XLEN-1:0]  dividend, divisor, quot, rema;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_tag(ex_tag),
    .ex_stall(ex_stall), .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .div_valid(div_valid), .div_signed(div_signed), .divw(divw),
    .dividend(dividend), .divisor(divisor), .div_flush(div_flush),
    .div_ready(div_ready), .out_valid(out_valid), .quot(quot), .rema(rema)
  );

  // Divider model: starts when div_valid is seen while idle, runs to completion
  // (even if flushed) and raises out_valid 129 cycles after the sequencer's accept.
  logic mBusy;
  int   mCnt;
  assign div_ready = !mBusy;
  assign out_valid = mBusy && (mCnt == 129);

  always @(posedge clk) begin
    if (reset) begin
      mBusy <= 1'b0;
      mCnt  <= 0;
    end else if (!mBusy) begin
      if (div_valid) begin
        mBusy <= 1'b1;
        mCnt  <= 2;
      end
    end else if (out_valid) begin
      mBusy <= 1'b0;
    end else begin
      mCnt <= mCnt + 1;
    end
  end

  function automatic logic [127:0] modelDiv(input logic [63:0] a, input logic [63:0] b,
                                            input logic s, input logic w);
    logic [63:0] q, r;
    int          sa, sb;
    longint      la, lb;
    if (w) begin
      sa = a[31:0];
      sb = b[31:0];
      if (b[31:0] == 32'd0) begin q = '1; r = a; end
      else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin q = a; r = '0; end
      else if (s) begin q = {32'd0, 32'(sa / sb)}; r = {32'd0, 32'(sa % sb)}; end
      else begin q = {32'd0, a[31:0] / b[31:0]}; r = {32'd0, a[31:0] % b[31:0]}; end
    end else begin
      la = a;
      lb = b;
      if (b == 64'd0) begin q = '1; r = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
      else if (s) begin q = 64'(la / lb); r = 64'(la % lb); end
      else begin q = a / b; r = a % b; end
    end
    return {q, r};
  endfunction

  logic [127:0] mRes;
  assign mRes = modelDiv(dividend, divisor, div_signed, divw);
  assign quot = mRes[127:64];
  assign rema = mRes[63:0];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in IDLE (cycle 0) and holds it until the result pulse; returns to IDLE.
  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] tag, output int lat, output logic [63:0] data,
                               output logic [4:0] rtag, output int dvCycles,
                               output logic dvAtRes, output logic stall0);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_rs1   = a;
    ex_rs2   = b;
    ex_tag   = tag;
    #1;
    stall0   = ex_stall;
    lat      = -1;
    dvCycles = 0;
    data     = '0;
    rtag     = '0;
    dvAtRes  = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (res_valid) begin
        lat     = c;
        data    = res_data;
        rtag    = res_tag;
        dvAtRes = div_valid;
        break;
      end
      if (div_valid) dvCycles++;
    end
    ex_valid = 1'b0;
    tick();
  endtask

  initial begin
    int          lat, dvCycles, firstRes, earlyDv;
    logic [63:0] data;
    logic [4:0]  rtag;
    logic        dvAtRes, stall0, stall50, stall129, dv131;

    reset = 1'b1; flush = 1'b0; ex_valid = 1'b0;
    ex_op = '0; ex_rs1 = '0; ex_rs2 = '0; ex_tag = '0;
    repeat (3) tick();
    checkOutput("rstResValid", 64'(res_valid), 64'd0);
    checkOutput("rstResData",  res_data, 64'd0);
    checkOutput("rstResTag",   64'(res_tag), 64'd0);
    checkOutput("rstDivValid", 64'(div_valid), 64'd0);
    checkOutput("rstStall",    64'(ex_stall), 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] DIV 100/7");
    applyStimulus(OP_DIV, 64'd100, 64'd7, 5'd3, lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("divLatency",  64'(lat), 64'd130);
    checkOutput("divData",     data, 64'd14);
    checkOutput("divTag",      64'(rtag), 64'd3);
    checkOutput("divDvCycles", 64'(dvCycles), 64'd129);
    checkOutput("divDvAtRes",  64'(dvAtRes), 64'd0);
    checkOutput("divStall0",   64'(stall0), 64'd1);
    checkOutput("divHoldValid", 64'(res_valid), 64'd0);
    checkOutput("divHoldData",  res_data, 64'd14);

    applyStimulus(OP_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("remwLatency", 64'(lat), 64'd130);
    checkOutput("remwData",    data, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(OP_DIVUW, 64'h8000_0000, 64'd1, 5'd6, lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("divuwLatency", 64'(lat), 64'd130);
    checkOutput("divuwData",    data, 64'hFFFF_FFFF_8000_0000);

    $display("[TB] special cases");
    applyStimulus(OP_DIVU, 64'd12345, 64'd0, 5'd8, lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("divuZeroLatency", 64'(lat), 64'd1);
    checkOutput("divuZeroData",    data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("divuZeroTag",     64'(rtag), 64'd8);
    checkOutput("divuZeroDv",      64'(dvCycles + int'(dvAtRes)), 64'd0);

    applyStimulus(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10,
                  lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("remOvfLatency", 64'(lat), 64'd1);
    checkOutput("remOvfData",    data, 64'd0);
    checkOutput("remOvfDv",      64'(dvCycles + int'(dvAtRes)), 64'd0);

    applyStimulus(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
                  lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("divOvfLatency", 64'(lat), 64'd1);
    checkOutput("divOvfData",    data, 64'h8000_0000_0000_0000);

    applyStimulus(OP_DIVW, 64'd77, 64'h0000_0001_0000_0000, 5'd12, lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("divwZeroLatency", 64'(lat), 64'd1);
    checkOutput("divwZeroData",    data, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("[TB] flush in IDLE and RESP");
    ex_valid = 1'b1; flush = 1'b1; ex_op = OP_DIVU; ex_rs1 = 64'd5; ex_rs2 = 64'd0; ex_tag = 5'd2;
    #1;
    checkOutput("idleFlushStall", 64'(ex_stall), 64'd0);
    checkOutput("idleDivFlush",   64'(div_flush), 64'd1);
    tick();
    checkOutput("idleFlushNoAccept", 64'(res_valid), 64'd0);
    flush = 1'b0;
    #1;
    checkOutput("idleAcceptStall", 64'(ex_stall), 64'd1);
    tick();
    checkOutput("respValid", 64'(res_valid), 64'd1);
    checkOutput("respData",  res_data, 64'hFFFF_FFFF_FFFF_FFFF);
    flush = 1'b1; ex_valid = 1'b0;
    #1;
    checkOutput("respFlushSuppress", 64'(res_valid), 64'd0);
    tick();
    flush = 1'b0;

    $display("[TB] flush at cycle 40 of DIV, new op at cycle 50");
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 64'd1000; ex_rs2 = 64'd10; ex_tag = 5'd7;
    for (int c = 1; c <= 40; c++) tick();
    flush = 1'b1; ex_valid = 1'b0;
    #1;
    checkOutput("busyDivFlush", 64'(div_flush), 64'd1);
    tick();
    flush = 1'b0;
    checkOutput("drainDivValid", 64'(div_valid), 64'd0);
    firstRes = -1; earlyDv = 0; stall50 = 1'b0; stall129 = 1'b0; dv131 = 1'b0; data = '0; rtag = '0;
    for (int c = 41; c <= 300; c++) begin
      if (c == 50) begin
        ex_valid = 1'b1; ex_op = OP_REMU; ex_rs1 = 64'd100; ex_rs2 = 64'd7; ex_tag = 5'd9;
        #1;
        stall50 = ex_stall;
      end
      if (c == 129) stall129 = ex_stall;
      if (c <= 130 && div_valid) earlyDv++;
      if (c == 131) dv131 = div_valid;
      if (res_valid) begin
        firstRes = c;
        data     = res_data;
        rtag     = res_tag;
        break;
      end
      tick();
    end
    ex_valid = 1'b0;
    tick();
    checkOutput("drainStall50",  64'(stall50), 64'd1);
    checkOutput("drainStall129", 64'(stall129), 64'd1);
    checkOutput("drainNoEarlyDv", 64'(earlyDv), 64'd0);
    checkOutput("drainDv131",    64'(dv131), 64'd1);
    checkOutput("drainResCycle", 64'(firstRes), 64'd260);
    checkOutput("drainResData",  data, 64'd2);
    checkOutput("drainResTag",   64'(rtag), 64'd9);

    $display("[TB] reset at cycle 60");
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs1 = 64'd100; ex_rs2 = 64'd7; ex_tag = 5'd5;
    for (int c = 1; c <= 60; c++) tick();
    reset = 1'b1; ex_valid = 1'b0;
    tick();
    checkOutput("midRstResValid", 64'(res_valid), 64'd0);
    checkOutput("midRstResData",  res_data, 64'd0);
    checkOutput("midRstResTag",   64'(res_tag), 64'd0);
    checkOutput("midRstDivValid", 64'(div_valid), 64'd0);
    checkOutput("midRstStall",    64'(ex_stall), 64'd0);
    reset = 1'b0;
    tick();
    applyStimulus(OP_DIV, 64'd100, 64'd7, 5'd5, lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("postRstLatency", 64'(lat), 64'd130);
    checkOutput("postRstData",    data, 64'd14);

    $display("[TB] REM/REMU 100/7 after DIV 100/7");
    applyStimulus(OP_REM, 64'd100, 64'd7, 5'd13, lat, data, rtag, dvCycles, dvAtRes, stall0);
`ifdef DIV_RESULT_CACHE_EN
    checkOutput("remCacheLatency", 64'(lat), 64'd1);
    checkOutput("remCacheDv",      64'(dvCycles), 64'd0);
`else
    checkOutput("remLatency",      64'(lat), 64'd130);
`endif
    checkOutput("remData", data, 64'd2);
    checkOutput("remTag",  64'(rtag), 64'd13);
    applyStimulus(OP_REMU, 64'd100, 64'd7, 5'd14, lat, data, rtag, dvCycles, dvAtRes, stall0);
    checkOutput("remuLatency", 64'(lat), 64'd130);
    checkOutput("remuData",    data, 64'd2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
